packet_tx_source: RTL and testbench

- Avalon-ST packet source that drives the same MAC-side stream (valid/ready/sop/eop/error) the sniffer controller consumes. Used as a bench/replay stimulus source and loopback generator.
- A writer loads complete packets word-by-word into an internal buffer.
- The block transmits each complete packet with correct framing, enforces an inter-packet gap, and supports mid-packet abort, signalled as error-terminated.

---
 rtl/packet_tx_source.sv | 232 +++++++++++++++++++++++
 tb/tb_packet_tx_source.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_tx_source.sv
// packet_tx_source: Avalon-ST packet source fed from an internal packet buffer.
// A writer loads complete packets word by word; each complete packet is sent
// with sop/eop framing, followed by an idle gap. An abort request during a
// packet ends it with an error-flagged eop beat and flushes the unsent words.
module packet_tx_source #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int MAX_PKTS = 16,
    parameter int GAP      = 2,
    localparam int EMPTY_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_last,
    input  logic [EMPTY_W-1:0] wr_empty,
    output logic               wr_full,
    output logic               overflow,

    input  logic               abort,

    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_sop,
    output logic               tx_eop,
    output logic [EMPTY_W-1:0] tx_empty,
    output logic               tx_error,

    output logic [15:0]        pkts_sent,
    output logic [15:0]        pkts_aborted
);

    localparam int AW    = $clog2(DEPTH);
    localparam int UW    = AW + 1;
    localparam int PW    = $clog2(MAX_PKTS + 1);
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int ENT_W = 1 + EMPTY_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_ABORT,
        S_FLUSH,
        S_GAP
    } state_t;

    // With no gap configured an eop/abort beat returns straight to IDLE.
    localparam state_t S_AFTER_EOP = (GAP == 0) ? S_IDLE : S_GAP;

    // Buffer storage: {last, empty, data} per word. Data only, never reset.
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]      used_q, used_d;
    logic [PW-1:0]      pending_q, pending_d;
    logic               overflow_q, overflow_d;

    state_t             state_q, state_d;
    logic               first_beat_q, first_beat_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [15:0]        sent_q, sent_d;
    logic [15:0]        aborted_q, aborted_d;

    logic               push;
    logic               pop;
    logic               full;

    logic [ENT_W-1:0]   head;
    logic               head_last;
    logic [EMPTY_W-1:0] head_empty;
    logic [DATA_W-1:0]  head_data;

    // Show-ahead head of the buffer: the word at the read pointer is always visible.
    assign head       = mem_q[rd_ptr_q];
    assign head_last  = head[ENT_W-1];
    assign head_empty = head[DATA_W +: EMPTY_W];
    assign head_data  = head[DATA_W-1:0];

    // Full when out of words or when the packet-count limit is reached.
    assign full = (used_q == UW'(DEPTH)) || (pending_q == PW'(MAX_PKTS));
    assign push = wr_en && !full;

    // Buffer write port: stores an accepted word at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_last, wr_empty, wr_data};
        end
    end

    // Transmit state machine: decides beats, pops, gap timing and packet counters.
    always_comb begin
        state_d      = state_q;
        first_beat_d = first_beat_q;
        gap_cnt_d    = gap_cnt_q;
        sent_d       = sent_q;
        aborted_d    = aborted_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d      = S_SEND;
                    first_beat_d = 1'b1;
                end
            end

            S_SEND: begin
                // Abort wins over the handshake: the current head is re-presented
                // as the error-terminated beat instead of being sent normally.
                if (abort) begin
                    state_d = S_ABORT;
                end else if (tx_ready) begin
                    pop          = 1'b1;
                    first_beat_d = 1'b0;
                    if (head_last) begin
                        sent_d    = sent_q + 16'd1;
                        gap_cnt_d = '0;
                        state_d   = S_AFTER_EOP;
                    end
                end
            end

            S_ABORT: begin
                if (tx_ready) begin
                    pop          = 1'b1;
                    first_beat_d = 1'b0;
                    aborted_d    = aborted_q + 16'd1;
                    gap_cnt_d    = '0;
                    state_d      = head_last ? S_AFTER_EOP : S_FLUSH;
                end
            end

            S_FLUSH: begin
                // The packet is complete in the buffer, so a last-flagged word
                // is guaranteed to arrive before the buffer runs dry.
                pop = 1'b1;
                if (head_last) begin
                    gap_cnt_d = '0;
                    state_d   = S_AFTER_EOP;
                end
            end

            S_GAP: begin
                // On the final gap cycle start the next packet directly, so the
                // idle time between packets is exactly GAP cycles.
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    if (pending_q != '0) begin
                        state_d      = S_SEND;
                        first_beat_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Buffer bookkeeping: pointers, occupancy, complete-packet count, overflow flag.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q || (wr_en && full);

        used_d = used_q;
        case ({push, pop})
            2'b10:   used_d = used_q + UW'(1);
            2'b01:   used_d = used_q - UW'(1);
            default: used_d = used_q;
        endcase

        pending_d = pending_q;
        case ({push && wr_last, pop && head_last})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Control registers with synchronous reset; reset drops any buffered data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            first_beat_q <= 1'b0;
            gap_cnt_q    <= '0;
            sent_q       <= '0;
            aborted_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            used_q       <= '0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_beat_q <= first_beat_d;
            gap_cnt_q    <= gap_cnt_d;
            sent_q       <= sent_d;
            aborted_q    <= aborted_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            used_q       <= used_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    // Stream outputs decode from the state register and the buffer head, so
    // they stay stable while the sink stalls; idle cycles drive zeros.
    always_comb begin
        tx_valid = (state_q == S_SEND) || (state_q == S_ABORT);
        tx_data  = tx_valid ? head_data : '0;
        tx_sop   = tx_valid && first_beat_q;
        tx_eop   = ((state_q == S_SEND) && head_last) || (state_q == S_ABORT);
        tx_empty = (state_q == S_SEND) ? head_empty : '0;
        tx_error = (state_q == S_ABORT);
    end

    assign wr_full      = full;
    assign overflow     = overflow_q;
    assign pkts_sent    = sent_q;
    assign pkts_aborted = aborted_q;

endmodule

// File: tb/tb_packet_tx_source.sv
// Directed bench for packet_tx_source with a beat scoreboard and a protocol monitor.
`timescale 1ns/1ps
module tb_packet_tx_source;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 256;
    localparam int MAX_PKTS = 16;
    localparam int GAP      = 2;
    localparam int EMPTY_W  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_last;
    logic [EMPTY_W-1:0] wr_empty;
    logic               wr_full;
    logic               overflow;
    logic               abort;
    logic               tx_ready;
    logic               tx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_sop;
    logic               tx_eop;
    logic [EMPTY_W-1:0] tx_empty;
    logic               tx_error;
    logic [15:0]        pkts_sent;
    logic [15:0]        pkts_aborted;

    always #5 clk = ~clk;

    packet_tx_source #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .MAX_PKTS(MAX_PKTS),
        .GAP     (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_empty    (wr_empty),
        .wr_full     (wr_full),
        .overflow    (overflow),
        .abort       (abort),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_empty    (tx_empty),
        .tx_error    (tx_error),
        .pkts_sent   (pkts_sent),
        .pkts_aborted(pkts_aborted)
    );

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               err;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_beat(input logic [DATA_W-1:0] d, input logic sop, input logic eop,
                               input logic [EMPTY_W-1:0] emp, input logic err);
        beat_t b;
        b.data  = d;
        b.sop   = sop;
        b.eop   = eop;
        b.empty = emp;
        b.err   = err;
        exp_q.push_back(b);
    endtask

    task automatic wr(input logic [DATA_W-1:0] d, input logic last, input logic [EMPTY_W-1:0] emp);
        wr_en    = 1'b1;
        wr_data  = d;
        wr_last  = last;
        wr_empty = emp;
        @(posedge clk); #1;
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        wr_empty = '0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    // Monitor state: stall hold tracking, in-packet tracking and gap measurement.
    logic  prev_stall = 1'b0;
    beat_t snap;
    beat_t cur;
    beat_t e;
    logic  in_pkt     = 1'b0;
    logic  gap_armed  = 1'b0;
    int    idle_run   = 0;
    int    last_gap   = -1;
    int    stall_cnt  = 0;

    // A cycle with abort high is not a transfer: the DUT converts the beat
    // into an error-terminated one on the following cycle.
    always @(negedge clk) begin
        cur.data  = tx_data;
        cur.sop   = tx_sop;
        cur.eop   = tx_eop;
        cur.empty = tx_empty;
        cur.err   = tx_error;
        if (rst) begin
            prev_stall = 1'b0;
            in_pkt     = 1'b0;
            gap_armed  = 1'b0;
            idle_run   = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", tx_valid, 1'b1);
                check("stall_hold_beat", cur, snap);
            end
            if (in_pkt) check("no_valid_drop_in_packet", tx_valid, 1'b1);
            if (tx_valid) begin
                if (tx_sop && gap_armed) begin
                    last_gap  = idle_run;
                    gap_armed = 1'b0;
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (tx_valid && tx_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data=%0h sop=%0b eop=%0b err=%0b, no beat expected (t=%0t)",
                             tx_data, tx_sop, tx_eop, tx_error, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", tx_data, e.data);
                    check("beat_sop_eop_err", {tx_sop, tx_eop, tx_error}, {e.sop, e.eop, e.err});
                    if (e.eop) check("beat_empty", tx_empty, e.empty);
                end
                if (tx_eop) begin
                    in_pkt    = 1'b0;
                    gap_armed = 1'b1;
                    idle_run  = 0;
                end else begin
                    in_pkt = 1'b1;
                end
            end
            prev_stall = tx_valid && !tx_ready && !abort;
            if (prev_stall) stall_cnt++;
            snap = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        wr_empty = '0;
        abort    = 1'b0;
        tx_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_flags", {tx_valid, tx_sop, tx_eop, tx_error}, 4'b0000);
        check("rst_tx_data", {tx_data, tx_empty}, '0);
        check("rst_full_ovf", {wr_full, overflow}, 2'b00);
        check("rst_counters", {pkts_sent, pkts_aborted}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: three-word packet, latency and framing
        expect_beat(32'hA000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_beat(32'hA000_0001, 1'b0, 1'b0, 2'd0, 1'b0);
        expect_beat(32'hA000_0002, 1'b0, 1'b1, 2'd2, 1'b0);
        wr(32'hA000_0000, 1'b0, 2'd0);
        wr(32'hA000_0001, 1'b0, 2'd0);
        @(negedge clk);
        check("no_start_incomplete", tx_valid, 1'b0);
        @(posedge clk); #1;
        wr(32'hA000_0002, 1'b1, 2'd2);
        @(negedge clk);
        check("latency_n1_idle", tx_valid, 1'b0);
        @(negedge clk);
        check("latency_n2_valid_sop", {tx_valid, tx_sop}, 2'b11);
        wait_drain(20);
        repeat (4) @(posedge clk);
        #1;
        check("t1_pkts_sent", pkts_sent, 16'd1);

        // 2: same shape, sink stalls three cycles on the second beat
        expect_beat(32'hA100_0000, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_beat(32'hA100_0001, 1'b0, 1'b0, 2'd0, 1'b0);
        expect_beat(32'hA100_0002, 1'b0, 1'b1, 2'd2, 1'b0);
        s0 = stall_cnt;
        wr(32'hA100_0000, 1'b0, 2'd0);
        wr(32'hA100_0001, 1'b0, 2'd0);
        wr(32'hA100_0002, 1'b1, 2'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_drain(20);
        repeat (4) @(posedge clk);
        #1;
        check("t2_stall_cycles", stall_cnt - s0, 3);
        check("t2_pkts_sent", pkts_sent, 16'd2);

        // 3: back-to-back single-word packets separated by exactly GAP idles
        expect_beat(32'hB0B0_B0B0, 1'b1, 1'b1, 2'd1, 1'b0);
        expect_beat(32'hC0C0_C0C0, 1'b1, 1'b1, 2'd3, 1'b0);
        wr(32'hB0B0_B0B0, 1'b1, 2'd1);
        wr(32'hC0C0_C0C0, 1'b1, 2'd3);
        wait_drain(20);
        repeat (3) @(posedge clk);
        #1;
        check("t3_gap_idle_cycles", last_gap, GAP);
        check("t3_pkts_sent", pkts_sent, 16'd4);

        // 4: five-word packet aborted on its second beat, rest flushed
        expect_beat(32'hD000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_beat(32'hD000_0001, 1'b0, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wr(32'hD000_0000 + DATA_W'(i), (i == 4), (i == 4) ? 2'd1 : 2'd0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_drain(20);
        repeat (8) @(posedge clk);
        #1;
        check("t4_pkts_aborted", pkts_aborted, 16'd1);
        check("t4_pkts_sent", pkts_sent, 16'd4);
        expect_beat(32'hE0E0_E0E0, 1'b1, 1'b1, 2'd0, 1'b0);
        wr(32'hE0E0_E0E0, 1'b1, 2'd0);
        wait_drain(20);
        repeat (4) @(posedge clk);
        #1;
        check("t4_next_pkts_sent", pkts_sent, 16'd5);

        // 5: fill to MAX_PKTS single-word packets, overflow, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < MAX_PKTS; i++) begin
            expect_beat(32'h0000_0500 + DATA_W'(i), 1'b1, 1'b1, 2'd0, 1'b0);
            wr(32'h0000_0500 + DATA_W'(i), 1'b1, 2'd0);
            if (i == MAX_PKTS - 2) begin
                @(negedge clk);
                check("t5_not_full_at_15", wr_full, 1'b0);
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("t5_full_at_16", wr_full, 1'b1);
        check("t5_no_overflow_yet", overflow, 1'b0);
        @(posedge clk); #1;
        wr(32'hDEAD_BEEF, 1'b1, 2'd0);
        @(negedge clk);
        check("t5_overflow_set", overflow, 1'b1);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_drain(200);
        repeat (6) @(posedge clk);
        #1;
        check("t5_pkts_sent", pkts_sent, 16'd21);
        check("t5_not_full_after_drain", wr_full, 1'b0);
        check("t5_overflow_sticky", overflow, 1'b1);

        // 6: reset in the middle of a four-word packet
        expect_beat(32'hF000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wr(32'hF000_0000 + DATA_W'(i), (i == 3), 2'd0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        check("t6_rst_tx_valid", tx_valid, 1'b0);
        check("t6_rst_counters", {pkts_sent, pkts_aborted}, '0);
        check("t6_rst_full_ovf", {wr_full, overflow}, 2'b00);
        repeat (6) @(posedge clk);
        #1;
        check("t6_stays_idle", tx_valid, 1'b0);
        expect_beat(32'h6060_0000, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_beat(32'h6060_0001, 1'b0, 1'b1, 2'd3, 1'b0);
        wr(32'h6060_0000, 1'b0, 2'd0);
        wr(32'h6060_0001, 1'b1, 2'd3);
        wait_drain(20);
        repeat (4) @(posedge clk);
        #1;
        check("t6_pkts_sent", pkts_sent, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
